instr_fetch: RTL and testbench

Instruction fetch stage of the 16-bit MISC-V core. Holds the program counter, issues in-order read requests to instruction memory and absorbs responses in a 2-entry buffer. Presents `{pc, instruction}` pairs to decode (register read and immediate generation) over a valid/ready handshake. Accepts a redirect from execute for branches and jumps, and drops stale in-flight fetches.

---
 rtl/misc_v_pkg.sv | 14 +
 rtl/fetch_buf.sv | 64 ++++++
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/misc_v_pkg.sv
// misc_v_pkg: shared widths, reset PC and the fetch packet type of the MISC-V core
package misc_v_pkg;

    localparam int XLEN = 16;
    localparam int ILEN = 16;
    localparam logic [XLEN-1:0] PC_STEP = 16'd2;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetch packets with flush, push, pop and occupancy count
module fetch_buf
    import misc_v_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  fetch_pkt_t push_pkt,
    input  logic       pop,
    output fetch_pkt_t head_pkt,
    output logic [1:0] count
);

    fetch_pkt_t mem_q [2];
    fetch_pkt_t mem_d [2];
    logic       rd_q, rd_d, wr_q, wr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_pop;

    assign do_pop   = pop && (cnt_q != 2'd0);
    assign head_pkt = mem_q[rd_q];
    assign count    = cnt_q;

    // flush wins over push/pop; otherwise write at wr, read at rd
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = 1'b0;
            wr_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_pkt;
                wr_d        = ~wr_q;
            end
            if (do_pop) rd_d = ~rd_q;
            cnt_d = cnt_q + {1'b0, push} - {1'b0, do_pop};
        end
    end

    // storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // the fetch credit scheme must never let a push land on a full buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && cnt_q == 2'd2));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, credit-limited in-order imem requests, response buffering and redirect handling
module instr_fetch
    import misc_v_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    logic [XLEN-1:0] req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
    logic [1:0]      out_q, out_d, drop_q, drop_d;
    logic            run_q, run_d;
    logic [1:0]      count;
    fetch_pkt_t      head;
    logic            accept, push, pop;
    logic [XLEN-1:0] target;

    assign target         = redirect_pc & 16'hFFFE;
    // run_q keeps requests quiet while in reset and for the edge that leaves it
    assign imem_req_valid = run_q && !redirect_valid
                          && ({1'b0, out_q} + {1'b0, count} < 3'(BUF_DEPTH));
    assign imem_req_addr  = req_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && drop_q == 2'd0 && !redirect_valid;
    assign id_valid       = count != 2'd0;
    assign pop            = id_valid && id_ready && !redirect_valid;
    assign id_pc          = head.pc;
    assign id_instr       = head.instr;

    fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (push),
        .push_pkt (fetch_pkt_t'{pc: rsp_pc_q, instr: imem_rsp_data}),
        .pop      (pop),
        .head_pkt (head),
        .count    (count)
    );

    // next PCs and counters; a redirect makes every in-flight fetch stale
    always_comb begin
        run_d    = 1'b1;
        req_pc_d = redirect_valid ? target : accept ? req_pc_q + PC_STEP : req_pc_q;
        rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + PC_STEP : rsp_pc_q;
        out_d    = out_q + {1'b0, accept} - {1'b0, imem_rsp_valid};
        drop_d   = redirect_valid ? out_q - {1'b0, imem_rsp_valid}
                 : (imem_rsp_valid && drop_q != 2'd0) ? drop_q - 2'd1 : drop_q;
    end

    // PC and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            req_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= 2'd0;
            drop_q   <= 2'd0;
        end else begin
            run_q    <= run_d;
            req_pc_q <= req_pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    // memory must not answer a request that was never accepted
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && out_q == 2'd0));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch with an in-order memory model
module tb_instr_fetch;
    import misc_v_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_req_addr, imem_rsp_data;
    logic        imem_rsp_valid;
    logic        id_valid, id_ready;
    logic [15:0] id_instr, id_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    fetch_pkt_t  exp_q[$];
    logic [15:0] req_q[$];
    int checks = 0, fails = 0, delivered = 0;
    int cyc = 0, lat = 0, rdy_pct = 100, idr_pct = 100;
    logic was_redir = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        fails++;
        $display("FAIL %s: event not observed (t=%0t)", name, $time);
    endtask

    // decode sees pc, pc+2, ... from the last restart point; requests follow the same order
    task automatic restart(input logic [15:0] pc);
        exp_q.delete();
        req_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(fetch_pkt_t'{pc: pc + 16'(2 * i), instr: mem_word(pc + 16'(2 * i))});
            req_q.push_back(pc + 16'(2 * i));
        end
    endtask

    // one cycle: observe handshakes, advance memory model, drive next inputs
    // mode 0: no redirect, 1: redirect to tgt, 2: redirect only if response and id handshake coincide
    task automatic step(input int mode, input logic [15:0] tgt, output logic fired);
        logic acc, rsp;
        logic [15:0] a;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        rsp = imem_rsp_valid;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp) void'(mq.pop_front());
        if (acc) begin
            mq.push_back('{addr: a, due: cyc + int'($urandom_range(0, lat))});
            check("credit_limit", 32'(mq.size() <= 2), 32'd1);
        end
        imem_rsp_valid = mq.size() != 0 && mq[0].due <= cyc;
        imem_rsp_data  = imem_rsp_valid ? mem_word(mq[0].addr) : 16'($urandom);
        imem_req_ready = int'($urandom_range(0, 99)) < rdy_pct;
        id_ready       = int'($urandom_range(0, 99)) < idr_pct;
        fired = (mode == 1) || (mode == 2 && imem_rsp_valid && id_valid && id_ready);
        redirect_valid = fired;
        redirect_pc    = fired ? tgt : 16'($urandom);
        if (fired) restart(tgt & 16'hFFFE);
    endtask

    task automatic steps(input int n);
        logic f;
        for (int i = 0; i < n; i++) step(0, 16'h0, f);
    endtask

    task automatic wait_two_outstanding(input string name);
        logic f;
        int i;
        for (i = 0; i < 40 && mq.size() != 2; i++) step(0, 16'h0, f);
        if (mq.size() != 2) miss(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        check({tag, "_id_pc"}, 32'(id_pc), 32'd0);
        check({tag, "_id_instr"}, 32'(id_instr), 32'd0);
    endtask

    // monitor: pops the scoreboard on every decode handshake and accepted request
    initial forever begin
        fetch_pkt_t p;
        @(negedge clk);
        if (rst_n) begin
            if (redirect_valid) begin
                check("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
            end else begin
                if (was_redir) check("empty_after_redirect", 32'(id_valid), 32'd0);
                if (id_valid && id_ready) begin
                    if (exp_q.size() == 0) miss("exp_q_underflow");
                    else begin
                        p = exp_q.pop_front();
                        check("id_pc", 32'(id_pc), 32'(p.pc));
                        check("id_instr", 32'(id_instr), 32'(p.instr));
                        delivered++;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    if (req_q.size() == 0) miss("req_q_underflow");
                    else check("req_addr", 32'(imem_req_addr), 32'(req_q.pop_front()));
                end
            end
            was_redir = redirect_valid;
        end else begin
            was_redir = 1'b0;
        end
    end

    initial begin
        logic f;
        int i;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        restart(DEFAULT_RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // streaming on a 1-cycle memory
        steps(20);

        // decode stall: buffer fills and requests stop
        idr_pct = 0;
        steps(5);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_id_valid", 32'(id_valid), 32'd1);
        idr_pct = 100;
        steps(10);

        // redirect to an odd target with two fetches in flight
        lat = 3;
        wait_two_outstanding("two_outstanding_before_redirect");
        step(1, 16'h0041, f);
        lat = 0;
        steps(15);

        // redirect coinciding with a response and a decode handshake
        f = 1'b0;
        for (i = 0; i < 40 && !f; i++) step(2, 16'h1230, f);
        if (!f) miss("coincident_redirect");
        steps(15);

        // PC wrap past 16'hFFFE
        step(1, 16'hFFFC, f);
        steps(12);

        // randomized traffic with random redirects
        lat = 2;
        rdy_pct = 70;
        idr_pct = 70;
        for (i = 0; i < 400; i++) step(($urandom_range(0, 19) == 0) ? 1 : 0, 16'($urandom), f);

        // asynchronous reset with two requests outstanding
        lat = 3;
        rdy_pct = 100;
        idr_pct = 100;
        steps(3);
        wait_two_outstanding("two_outstanding_before_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mq.delete();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        restart(DEFAULT_RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 0;
        steps(20);

        check("progress", 32'(delivered >= 60), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
